regfile_scb: RTL and testbench

Parametrised multi-register file with two combinational read ports, one write port, a per-register pending scoreboard and optional write-to-read bypass. It is the next-generation architectural register file for the pipelined datapath. Decode reserves a destination register at issue, and writeback clears the reservation. Each read port reports whether its data is valid, so the hazard unit can stall on `read1Valid`/`read2Valid` instead of comparing register numbers itself.

---
 rtl/regfile_scb.sv | 99 +++++++++
 tb/tb_regfile_scb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scb.sv
// Register file with two combinational read ports, one write port and a per-register pending scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_scb #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int SELW  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SELW-1:0]   read1RegSel,
    input  logic [SELW-1:0]   read2RegSel,
    output logic [WIDTH-1:0]  read1Data,
    output logic [WIDTH-1:0]  read2Data,
    output logic              read1Valid,
    output logic              read2Valid,
    input  logic [SELW-1:0]   writeRegSel,
    input  logic [WIDTH-1:0]  writeData,
    input  logic              writeEn,
    input  logic [SELW-1:0]   reserveRegSel,
    input  logic              reserveEn,
    input  logic              flush,
    output logic [SELW:0]     pendCount,
    output logic              err
);

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_nxt;
    logic [SELW:0]    pend_cnt_nxt;
    logic             err_nxt;
    logic             we_xz;

    // Reserve is applied last so it wins over both the write clear and flush.
    always_comb begin
        pend_nxt = pend;
        if (writeEn) pend_nxt[writeRegSel] = 1'b0;
        if (flush) pend_nxt = '0;
        if (reserveEn) pend_nxt[reserveRegSel] = 1'b1;
    end

    always_comb begin
        pend_cnt_nxt = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            pend_cnt_nxt = pend_cnt_nxt + {{SELW{1'b0}}, pend_nxt[i]};
        end
    end

    always_comb begin
        we_xz   = ~(writeEn | ~writeEn);
        err_nxt = (writeEn & ~pend[writeRegSel] & ~flush)
                | (reserveEn & pend[reserveRegSel]
                   & ~(writeEn & (writeRegSel == reserveRegSel)))
                | we_xz;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pend      <= '0;
            pendCount <= '0;
            err       <= 1'b0;
        end else begin
            if (writeEn) regs[writeRegSel] <= writeData;
            pend      <= pend_nxt;
            pendCount <= pend_cnt_nxt;
            err       <= err_nxt;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic wr_hit_ok;
    assign wr_hit_ok = writeEn & ~(reserveEn & (reserveRegSel == writeRegSel));

    always_comb begin
        read1Data  = regs[read1RegSel];
        read1Valid = ~pend[read1RegSel];
        read2Data  = regs[read2RegSel];
        read2Valid = ~pend[read2RegSel];
        if (wr_hit_ok && (writeRegSel == read1RegSel)) begin
            read1Data  = writeData;
            read1Valid = 1'b1;
        end
        if (wr_hit_ok && (writeRegSel == read2RegSel)) begin
            read2Data  = writeData;
            read2Valid = 1'b1;
        end
    end
`else
    always_comb begin
        read1Data  = regs[read1RegSel];
        read1Valid = ~pend[read1RegSel];
        read2Data  = regs[read2RegSel];
        read2Valid = ~pend[read2RegSel];
    end
`endif

endmodule

// File: tb/tb_regfile_scb.sv
// Scoreboard bench for regfile_scb: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_regfile_scb;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam int SELW  = $clog2(NREGS);

    logic              clk = 1'b0;
    logic              rst;
    logic [SELW-1:0]   r1s, r2s, ws, rs;
    logic [WIDTH-1:0]  d1, d2, wd;
    logic              v1, v2, we, re, fl;
    logic [SELW:0]     cnt;
    logic              err;

    regfile_scb #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst),
        .read1RegSel(r1s), .read2RegSel(r2s),
        .read1Data(d1), .read2Data(d2),
        .read1Valid(v1), .read2Valid(v2),
        .writeRegSel(ws), .writeData(wd), .writeEn(we),
        .reserveRegSel(rs), .reserveEn(re), .flush(fl),
        .pendCount(cnt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d1, d2;
        logic             v1, v2;
        logic [SELW:0]    cnt;
        logic             err;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference state: register values, pending flags, registered outputs.
    logic [WIDTH-1:0] mreg [NREGS];
    bit               mpend [NREGS];
    int               mcnt;
    bit               merr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("read1Data",  32'(d1),  32'(e.d1));
            check("read2Data",  32'(d2),  32'(e.d2));
            check("read1Valid", 32'(v1),  32'(e.v1));
            check("read2Valid", 32'(v2),  32'(e.v2));
            check("pendCount",  32'(cnt), 32'(e.cnt));
            check("err",        32'(err), 32'(e.err));
        end
    end

    // Apply current inputs for one cycle: record expected outputs, then advance the model.
    task automatic step();
        exp_t e;
        bit   we1, xz, hit_ok;
        bit   np [NREGS];
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mreg[i] = '0;
                mpend[i] = 0;
            end
            mcnt = 0;
            merr = 0;
        end
        we1 = (we === 1'b1);
        xz  = $isunknown(we);
        e.d1  = mreg[r1s];
        e.d2  = mreg[r2s];
        e.v1  = !mpend[r1s];
        e.v2  = !mpend[r2s];
        e.cnt = (SELW+1)'(mcnt);
        e.err = merr;
`ifdef REGFILE_BYPASS_EN
        hit_ok = we1 && !(re && rs == ws);
        if (hit_ok && ws == r1s) begin e.d1 = wd; e.v1 = 1; end
        if (hit_ok && ws == r2s) begin e.d2 = wd; e.v2 = 1; end
`else
        hit_ok = 0;
`endif
        q.push_back(e);
        if (rst) begin
            merr = (we1 && !mpend[ws] && !fl)
                || (re && mpend[rs] && !(we1 && ws == rs))
                || xz;
            mcnt = 0;
            for (int i = 0; i < NREGS; i++) begin
                np[i] = (re && rs == i) || (!fl && mpend[i] && !(we1 && ws == i));
                if (np[i]) mcnt++;
            end
            for (int i = 0; i < NREGS; i++) mpend[i] = np[i];
            if (we1) mreg[ws] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; re = 0; fl = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; r1s = 0; r2s = 0; ws = 0; rs = 0; wd = 0;
        idle();
        @(posedge clk);
        #1;
        step();                          // reset state
        rst = 1;

        // Basic reserve then write of r3
        re = 1; rs = 3; step();
        idle(); r1s = 3; step();
        we = 1; ws = 3; wd = 16'hBEEF; step();
        idle(); step();

        // Bypass case on r5 via port 2
        re = 1; rs = 5; step();
        idle(); we = 1; ws = 5; wd = 16'h1234; r2s = 5; step();
        idle(); step();

        // Simultaneous reserve + write on a pending r2
        re = 1; rs = 2; step();
        idle(); re = 1; rs = 2; we = 1; ws = 2; wd = 16'hABCD; r1s = 2; step();
        idle(); step();
        we = 1; ws = 2; wd = 16'h0042; step();
        idle(); step();

        // Flush with simultaneous reserve of r7
        re = 1; rs = 1; step();
        rs = 4; step();
        rs = 6; step();
        fl = 1; rs = 7; r1s = 7; r2s = 4; step();
        idle(); step();
        we = 1; ws = 7; wd = 16'h7777; step();
        idle(); step();

        // Fill every register: count saturates at NREGS
        for (int i = 0; i < NREGS; i++) begin
            re = 1; rs = SELW'(i); step();
        end
        idle(); step();
        fl = 1; step();
        idle(); step();

        // Protocol errors
        we = 1; ws = 0; wd = 16'h0BAD; step();
        idle(); step(); step();
        re = 1; rs = 2; step();
        step();
        idle(); step(); step();
        we = 1; ws = 2; wd = 16'h2222; step();
        idle(); step();
        fl = 1; ws = 3; wd = mreg[3]; r1s = 0; r2s = 1; we = 1'bx; step();
        idle(); step(); step();

        // Reset in the middle of outstanding reservations
        re = 1; rs = 1; step();
        rs = 2; we = 1; ws = 6; wd = 16'h6666; step();
        idle(); r1s = 1; r2s = 6; rst = 0; step();
        rst = 1; step(); step();

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            r1s = SELW'($urandom_range(0, NREGS-1));
            r2s = SELW'($urandom_range(0, NREGS-1));
            ws  = SELW'($urandom_range(0, NREGS-1));
            rs  = SELW'($urandom_range(0, NREGS-1));
            wd  = WIDTH'($urandom);
            we  = ($urandom_range(0, 2) == 0);
            re  = ($urandom_range(0, 2) == 0);
            fl  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 4) == 0) r1s = ws;
            if ($urandom_range(0, 4) == 0) r2s = ws;
            rst = ($urandom_range(0, 79) != 0);
            step();
            rst = 1;
        end
        idle(); step();

        for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations expected 0", q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
